// File: rtl/memoreer.sv
// rtl/memoreer.sv - load/store functional unit answering scoreboard issues as MEMOREER_0
module memoreer (
    input  logic        clk,
    input  logic        CPU_RESET_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_op,
    input  logic [2:0]  issue_dest,
    input  logic [15:0] issue_base,
    input  logic [15:0] issue_offset,
    input  logic [15:0] issue_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [2:0]  wb_dest,
    output logic [15:0] wb_value,
    output logic [2:0]  wb_fu,
    output logic        complete,
    output logic [2:0]  complete_fu
);

    localparam logic [2:0] FU_ID    = 3'h2;
    localparam logic [2:0] DO_LOAD  = 3'h2;
    localparam logic [2:0] DO_STORE = 3'h3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_dest;
    logic        w_legal_op;
    logic        w_accept;
    logic [15:0] w_eff_addr;

    assign issue_ready = (r_state == S_IDLE) && CPU_RESET_n;
    assign w_legal_op  = (issue_op == DO_LOAD) || (issue_op == DO_STORE);
    assign w_accept    = issue_valid && issue_ready && w_legal_op;
    assign w_eff_addr  = issue_base + issue_offset;
    assign wb_fu       = FU_ID;
    assign complete_fu = FU_ID;

    always_ff @(posedge clk) begin
        if (!CPU_RESET_n) begin
            r_state   <= S_IDLE;
            r_dest    <= 3'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            wb_valid  <= 1'b0;
            wb_dest   <= 3'd0;
            wb_value  <= 16'd0;
            complete  <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_MEM;
                        r_dest    <= issue_dest;
                        mem_req   <= 1'b1;
                        mem_we    <= (issue_op == DO_STORE);
                        mem_addr  <= w_eff_addr;
                        mem_wdata <= issue_data;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        // r7 is hard-wired, so a load into it finishes like a store
                        if (mem_we || (r_dest == 3'd7)) begin
                            r_state  <= S_IDLE;
                            complete <= 1'b1;
                        end else begin
                            r_state  <= S_WB;
                            wb_valid <= 1'b1;
                            wb_dest  <= r_dest;
                            wb_value <= mem_rdata;
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_state  <= S_IDLE;
                        wb_valid <= 1'b0;
                        complete <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
